// File: rtl/instr_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats, control bundle
// and the immediate generator used by the decode stage.
package instr_decode_pkg;

  localparam int AW = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic branch;
    logic jal;
    logic jalr;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
    logic alu_src;
    logic illegal;
  } ctrl_t;

  // B and J offsets are halfword-aligned, so bit 0 is always zero.
  function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_fmt_e fmt);
    case (fmt)
      IMM_I:   gen_imm = {{20{i[31]}}, i[31:20]};
      IMM_S:   gen_imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   gen_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   gen_imm = {i[31:12], 12'h000};
      IMM_J:   gen_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: gen_imm = '0;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode_reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, x0 hard-wired to zero, whole array cleared on rst.
module instr_decode_reg_file
  import instr_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREGS];

  // NOTE: this array is reset on purpose (architectural state must read 0 after rst);
  // the loop keeps it a flop array rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/instr_decode.sv
// RV32I decode stage: control decode, immediate generation and operand read
// with writeback bypass, captured into one stall/flush-controlled register.
module instr_decode
  import instr_decode_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc_in,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm32,
  output logic [AW-1:0]   rd_addr,
  output logic [2:0]      funct3,
  output logic            funct7b5,
  output logic [XLEN-1:0] pc_out,
  output logic            branch,
  output logic            jal,
  output logic            jalr,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src,
  output logic            illegal,
  output logic            out_valid
);

  logic [6:0]      opcode;
  logic [AW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;
  logic [XLEN-1:0] op1, op2;
  ctrl_t           ctrl_d, ctrl_q;
  imm_fmt_e        fmt;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];

  instr_decode_reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  // Same-cycle writeback must be visible to the instruction being decoded.
  assign op1 = (wb_en && wb_addr == rs1 && rs1 != '0) ? wb_data : rf_rdata1;
  assign op2 = (wb_en && wb_addr == rs2 && rs2 != '0) ? wb_data : rf_rdata2;

  // NOTE: defaults first so every path assigns ctrl_d and fmt -- no latches.
  always_comb begin
    ctrl_d = '0;
    fmt    = IMM_NONE;
    case (opcode)
      OPC_OP:     ctrl_d.reg_write = 1'b1;
      OPC_OP_IMM: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        fmt              = IMM_I;
      end
      OPC_LOAD: begin
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        fmt               = IMM_I;
      end
      OPC_STORE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        fmt              = IMM_S;
      end
      OPC_BRANCH: begin
        ctrl_d.branch = 1'b1;
        fmt           = IMM_B;
      end
      OPC_JAL: begin
        ctrl_d.jal       = 1'b1;
        ctrl_d.reg_write = 1'b1;
        fmt              = IMM_J;
      end
      OPC_JALR: begin
        ctrl_d.jalr      = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        fmt              = IMM_I;
      end
      OPC_LUI, OPC_AUIPC: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        fmt              = IMM_U;
      end
      default:    ctrl_d.illegal = 1'b1;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      rs1_data  <= '0;
      rs2_data  <= '0;
      imm32     <= '0;
      rd_addr   <= '0;
      funct3    <= '0;
      funct7b5  <= 1'b0;
      pc_out    <= RESET_PC;
    end else if (flush) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      rd_addr   <= '0;
    end else if (!stall) begin
      out_valid <= in_valid;
      ctrl_q    <= in_valid ? ctrl_d : '0;
      rs1_data  <= op1;
      rs2_data  <= op2;
      imm32     <= gen_imm(instruction, fmt);
      rd_addr   <= (in_valid && ctrl_d.reg_write) ? rd : '0;
      funct3    <= instruction[14:12];
      funct7b5  <= instruction[30];
      pc_out    <= pc_in;
    end
  end

  assign branch     = ctrl_q.branch;
  assign jal        = ctrl_q.jal;
  assign jalr       = ctrl_q.jalr;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign alu_src    = ctrl_q.alu_src;
  assign illegal    = ctrl_q.illegal;

endmodule
